// File: rtl/demux_pkg.sv
// demux_pkg: shared sizing for the registered 1-to-4 demultiplexer
package demux_pkg;
  localparam int N_OUT = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one output holding register with valid flag and delivery counter
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output cnt_t             count,
  output logic             free
);
  logic drain;
  assign drain = valid && ready;
  assign free  = !valid || ready;
  // load replaces the word; valid survives only a reload or a stalled hold; drains are counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
      count <= '0;
    end else begin
      if (load) data <= din;
      valid <= load || (valid && !ready);
      if (drain) count <= count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/demux4_reg.sv
// demux4_reg: routes a ready/valid word into one of four registered output slots
module demux4_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [N_OUT-1:0][WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]            out_valid,
  input  logic [N_OUT-1:0]            out_ready,
  output logic [N_OUT-1:0][CNT_W-1:0] out_count
);
  logic [N_OUT-1:0] free;
  assign in_ready = free[in_sel];
  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (in_valid && in_ready && (in_sel == SEL_W'(i))),
      .din   (in_data),
      .ready (out_ready[i]),
      .data  (out_data[i]),
      .valid (out_valid[i]),
      .count (out_count[i]),
      .free  (free[i])
    );
  end
endmodule

// File: tb/tb_demux4_reg.sv
// tb_demux4_reg: directed self-checking bench for demux4_reg
module tb_demux4_reg;
  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      in_data;
  logic [1:0]      in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [3:0][7:0] out_data;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [3:0][7:0] out_count;
  int passed = 0;
  int total = 0;

  demux4_reg #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [7:0] d);
    in_sel = s;
    in_data = d;
    in_valid = 1'b1;
  endtask

  initial begin
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst_n = 1'b0;
    in_data = 8'hFF;
    in_sel = 2'd0;
    in_valid = 1'b1;
    out_ready = 4'b0000;
    step();
    step();
    check("rst_valid", out_valid, 4'b0000);
    check("rst_count", out_count, 32'h0);
    check("rst_data", out_data, 32'h0);
    for (int k = 0; k < 4; k++) begin
      in_sel = 2'(k);
      #1;
      check($sformatf("rst_in_ready%0d", k), in_ready, 1'b1);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      send(2'(k), vals[k]);
      #1;
      check($sformatf("route_in_ready%0d", k), in_ready, 1'b1);
      step();
      check($sformatf("route_valid%0d", k), out_valid[k], 1'b1);
      check($sformatf("route_data%0d", k), out_data[k], vals[k]);
    end
    in_valid = 1'b0;
    step();
    check("route_drained", out_valid, 4'b0000);
    check("route_counts", out_count, 32'h01010101);
    check("route_data_kept", out_data, 32'h44332211);
    out_ready = 4'b1101;
    send(2'd1, 8'h5A);
    step();
    check("bp_first", out_data[1], 8'h5A);
    send(2'd1, 8'h6B);
    #1;
    check("bp_in_ready_low", in_ready, 1'b0);
    step();
    check("bp_held", out_data[1], 8'h5A);
    check("bp_held_valid", out_valid[1], 1'b1);
    out_ready[1] = 1'b1;
    #1;
    check("bp_in_ready_high", in_ready, 1'b1);
    step();
    check("bp_second", out_data[1], 8'h6B);
    check("bp_second_valid", out_valid[1], 1'b1);
    check("bp_count", out_count[1], 8'd2);
    in_valid = 1'b0;
    step();
    check("bp_count_final", out_count[1], 8'd3);
    out_ready[3] = 1'b0;
    send(2'd3, 8'h3F);
    step();
    check("sim_full", out_valid[3], 1'b1);
    out_ready[3] = 1'b1;
    send(2'd3, 8'hC3);
    step();
    check("sim_valid", out_valid[3], 1'b1);
    check("sim_data", out_data[3], 8'hC3);
    check("sim_count", out_count[3], 8'd2);
    in_valid = 1'b0;
    step();
    check("sim_drain", out_valid[3], 1'b0);
    check("sim_count_final", out_count[3], 8'd3);
    out_ready[0] = 1'b0;
    send(2'd0, 8'h77);
    step();
    for (int i = 0; i < 5; i++) begin
      send(2'd2, 8'(8'h80 + i));
      #1;
      check($sformatf("ind_in_ready%0d", i), in_ready, 1'b1);
      step();
      check($sformatf("ind_data%0d", i), out_data[2], 8'(8'h80 + i));
      check($sformatf("ind_valid%0d", i), out_valid[2], 1'b1);
    end
    in_valid = 1'b0;
    step();
    check("ind_count2", out_count[2], 8'd6);
    check("ind_slot0_data", out_data[0], 8'h77);
    check("ind_slot0_valid", out_valid[0], 1'b1);
    check("ind_slot0_count", out_count[0], 8'd1);
    out_ready[2] = 1'b0;
    send(2'd2, 8'hA5);
    step();
    in_valid = 1'b0;
    check("pre_rst_held", out_data[2], 8'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 4'b0000);
    check("async_rst_count", out_count, 32'h0);
    check("async_rst_data", out_data, 32'h0);
    step();
    rst_n = 1'b1;
    out_ready = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      send(2'd0, 8'(i));
      step();
    end
    check("wrap_255", out_count[0], 8'd255);
    in_valid = 1'b0;
    step();
    check("wrap_256", out_count[0], 8'd0);
    send(2'd0, 8'hEE);
    step();
    in_valid = 1'b0;
    step();
    check("wrap_257", out_count[0], 8'd1);
    check("wrap_last_data", out_data[0], 8'hEE);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/demux4_reg.md
DEMUX4_REG -- requirements
Module: demux4_reg

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, data width in bits.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_data  input  WIDTH  word to route.
REQ-005 SHALL have port: in_sel  input  2  destination output index 0..3.
REQ-006 SHALL have port: in_valid  input  1  in_data/in_sel valid.
REQ-007 SHALL have port: in_ready  output  1  block accepts the offered word this cycle.
REQ-008 SHALL have port: out_data  output  4 x WIDTH  held word per output k.
REQ-009 SHALL have port: out_valid  output  4  out_data[k] valid.
REQ-010 SHALL have port: out_ready  input  4  consumer k takes out_data[k].
REQ-011 SHALL have port: out_count  output  4 x 8  words delivered per output k.

Function
REQ-012 SHALL hold one word per output in slot k (data register plus valid flag).
REQ-013 SHALL define slot k free as !out_valid[k] || out_ready[k].
REQ-014 SHALL drive in_ready combinationally as free of slot in_sel; independent of in_valid.
REQ-015 SHALL accept a word when in_valid && in_ready; slot in_sel loads in_data, out_valid[in_sel]=1 on the next edge (latency 1 cycle).
REQ-016 SHALL complete a drain of slot k when out_valid[k] && out_ready[k]; out_valid[k] clears next edge unless reloaded.
REQ-017 SHALL, on simultaneous drain and accept on the same slot, load the new word and keep out_valid[k]=1 (no bubble, no loss).
REQ-018 SHALL hold out_data[k] stable while out_valid[k] && !out_ready[k] (backpressure).
REQ-019 SHALL leave slots other than in_sel unaffected by an accept; all four slots may drain in the same cycle.
REQ-020 SHALL ignore in_data/in_sel when in_valid=0 (no state change).
REQ-021 SHALL increment out_count[k] by 1 on each drain of slot k, wrapping 255 -> 0.
REQ-022 SHALL never duplicate, drop or reorder words routed to the same output.
REQ-023 SHALL keep out_data[k] unchanged after a drain until the next load (no clear to zero).

Reset
REQ-024 SHALL, on rst_n=0, immediately clear out_valid to 4'b0000, out_data to 0, out_count to 0, independent of clk.
REQ-025 SHALL discard any held word when reset asserts mid-operation; no drain is counted for it.
REQ-026 SHALL drive in_ready=1 during reset for every in_sel (all slots empty), but accept nothing until the first edge after rst_n=1.

Structure
REQ-027 SHALL take N_OUT=4, SEL_W=2, CNT_W=8 from shared package demux_pkg.
REQ-028 SHALL implement each output as sub-module demux_slot (data register, valid flag, counter), instantiated 4 times.
REQ-029 SHALL contain no latches and no combinational path from in_data to out_data.

Verification
REQ-030 Reset: rst_n=0 mid-stream with slot 2 holding 8'hA5 -> out_valid=0000, out_count all 0, out_data all 0, with no clock edge needed.
REQ-031 Routing: send 8'h11,8'h22,8'h33,8'h44 with in_sel 0,1,2,3, out_ready=1111 -> each appears on matching output one cycle after accept; out_count each 1.
REQ-032 Backpressure: out_ready[1]=0, send 8'h5A to sel 1 then 8'h6B to sel 1 -> in_ready=0 for second; out_data[1]=8'h5A held; on out_ready[1]=1, 8'h6B accepted that cycle and shown next cycle.
REQ-033 Simultaneous: slot 3 full, out_ready[3]=1 and new word 8'hC3 to sel 3 same cycle -> out_valid[3] stays 1, out_data[3]=8'hC3 next cycle, out_count[3] +1.
REQ-034 Independence: out_ready[0]=0 holding slot 0, stream to sel 2 every cycle -> in_ready=1 throughout, one word per cycle on output 2, slot 0 unchanged.
REQ-035 Wrap: 256 drains on output 0 -> out_count[0] returns to 0; 257th drain gives 1.
